// File: rtl/cc_flag_if.sv
// Signal bundle for cc_flag_unit. The C/V carry/overflow signals exist only
// when CC_CV_FLAGS_EN is defined.
interface cc_flag_if #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STACK_DEPTH = 4
);
  localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);
`ifdef CC_CV_FLAGS_EN
  localparam int unsigned PsrW = 5;
`else
  localparam int unsigned PsrW = 3;
`endif

  logic [WIDTH-1:0] Buss;
  logic             flagWE;
  logic             ld_psr;
  logic [PsrW-1:0]  psr_in;
  logic             push;
  logic             pop;
  logic             err_clr;
  logic [2:0]       br_mask;
  logic             N;
  logic             Z;
  logic             P;
  logic             br_taken;
  logic [CntW-1:0]  stk_count;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_err;
`ifdef CC_CV_FLAGS_EN
  logic             carry_in;
  logic             ovf_in;
  logic             C;
  logic             V;

  modport master (
    output Buss, flagWE, ld_psr, psr_in, push, pop, err_clr, br_mask, carry_in, ovf_in,
    input  N, Z, P, C, V, br_taken, stk_count, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  Buss, flagWE, ld_psr, psr_in, push, pop, err_clr, br_mask, carry_in, ovf_in,
    output N, Z, P, C, V, br_taken, stk_count, stk_full, stk_empty, stk_err
  );
`else
  modport master (
    output Buss, flagWE, ld_psr, psr_in, push, pop, err_clr, br_mask,
    input  N, Z, P, br_taken, stk_count, stk_full, stk_empty, stk_err
  );

  modport slave (
    input  Buss, flagWE, ld_psr, psr_in, push, pop, err_clr, br_mask,
    output N, Z, P, br_taken, stk_count, stk_full, stk_empty, stk_err
  );
`endif
endinterface

// File: rtl/cc_flag_unit.sv
// Condition-code unit: N/Z/P flags, PSR load, save/restore stack, BR decision.
// Define CC_CV_FLAGS_EN to add carry (C) and overflow (V) flags.
module cc_flag_unit #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  cc_flag_if.slave cc_io
);
  localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
`ifdef CC_CV_FLAGS_EN
  localparam int unsigned FlagW = 5;
`else
  localparam int unsigned FlagW = 3;
`endif
  localparam logic [FlagW-1:0] FlagsRst = FlagW'(3'b010);
  localparam logic [CntW-1:0]  CntFull  = CntW'(STACK_DEPTH);

  // Flag vector layout is {[C,V,]N,Z,P}; N/Z/P always occupy the low three bits.
  logic [FlagW-1:0] flags_q, flags_d;
  logic [FlagW-1:0] stack_q [STACK_DEPTH];
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             err_q, err_d;

  logic [2:0]       nzp_v;
  logic [FlagW-1:0] derived;
  logic             is_full, is_empty;
  logic             push_ok, pop_ok, swap, err_set, stk_we;
  logic [IdxW-1:0]  wr_idx, top_idx, we_idx;

  always_comb begin
    nzp_v[2] = cc_io.Buss[WIDTH-1];
    nzp_v[1] = (cc_io.Buss == '0);
    nzp_v[0] = ~nzp_v[2] & ~nzp_v[1];
  end

`ifdef CC_CV_FLAGS_EN
  assign derived = {cc_io.carry_in, cc_io.ovf_in, nzp_v};
`else
  assign derived = nzp_v;
`endif

  assign is_full  = (cnt_q == CntFull);
  assign is_empty = (cnt_q == '0);
  assign wr_idx   = IdxW'(cnt_q);
  assign top_idx  = IdxW'(cnt_q - CntW'(1));

  always_comb begin
    push_ok = cc_io.push & ~cc_io.pop & ~is_full;
    pop_ok  = cc_io.pop & ~cc_io.push & ~is_empty;
    swap    = cc_io.push & cc_io.pop & ~is_empty;
    // A pop on an empty stack is an error whether or not push is also asserted.
    err_set = (cc_io.push & ~cc_io.pop & is_full) | (cc_io.pop & is_empty);
    stk_we  = push_ok | swap;
    we_idx  = swap ? top_idx : wr_idx;

    cnt_d = cnt_q;
    if (push_ok) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (pop_ok) begin
      cnt_d = cnt_q - CntW'(1);
    end

    flags_d = flags_q;
    if (pop_ok || swap) begin
      flags_d = stack_q[top_idx];
    end else if (cc_io.ld_psr) begin
      flags_d = cc_io.psr_in;
    end else if (cc_io.flagWE) begin
      flags_d = derived;
    end

    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (cc_io.err_clr) begin
      err_d = 1'b0;
    end
  end

  // Stack entries are not reset; they only hold still while reset is asserted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= FlagsRst;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (stk_we) begin
        stack_q[we_idx] <= flags_q;
      end
    end
  end

  assign cc_io.N         = flags_q[2];
  assign cc_io.Z         = flags_q[1];
  assign cc_io.P         = flags_q[0];
  assign cc_io.br_taken  = |(cc_io.br_mask & flags_q[2:0]);
  assign cc_io.stk_count = cnt_q;
  assign cc_io.stk_full  = is_full;
  assign cc_io.stk_empty = is_empty;
  assign cc_io.stk_err   = err_q;
`ifdef CC_CV_FLAGS_EN
  assign cc_io.C         = flags_q[4];
  assign cc_io.V         = flags_q[3];
`endif

endmodule

// File: tb/tb_cc_flag_unit.sv
// Self-checking bench for cc_flag_unit: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_cc_flag_unit;
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
`ifdef CC_CV_FLAGS_EN
  localparam int unsigned FW = 5;
`else
  localparam int unsigned FW = 3;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cc_flag_if #(.WIDTH(W), .STACK_DEPTH(D)) cc_io ();
  cc_flag_unit #(.WIDTH(W), .STACK_DEPTH(D)) dut (.clk(clk), .reset(reset), .cc_io(cc_io));

  cc_flag_if #(.WIDTH(8), .STACK_DEPTH(D)) io8 ();
  cc_flag_unit #(.WIDTH(8), .STACK_DEPTH(D)) dut8 (.clk(clk), .reset(reset), .cc_io(io8));

  int checks   = 0;
  int failures = 0;

  // Reference model: flags as {C,V,N,Z,P}; the stack is a plain queue.
  logic [4:0] m_flags = 5'b00010;
  logic [4:0] m_stack[$];
  logic       m_err   = 1'b0;

  function automatic logic [2:0] derive(input logic [W-1:0] v);
    if (v == 0) return 3'b010;
    if (longint'(v) >= (longint'(1) << (W - 1))) return 3'b100;
    return 3'b001;
  endfunction

  function automatic logic [4:0] psr5();
`ifdef CC_CV_FLAGS_EN
    return cc_io.psr_in;
`else
    return {2'b00, cc_io.psr_in};
`endif
  endfunction

  function automatic logic [1:0] cv_in();
`ifdef CC_CV_FLAGS_EN
    return {cc_io.carry_in, cc_io.ovf_in};
`else
    return 2'b00;
`endif
  endfunction

  task automatic model_step();
    logic [4:0] pre;
    logic [4:0] nxt;
    logic       set;
    pre = m_flags;
    nxt = m_flags;
    set = 1'b0;
    if (cc_io.ld_psr) nxt = psr5();
    else if (cc_io.flagWE) nxt = {cv_in(), derive(cc_io.Buss)};
    if (cc_io.pop && m_stack.size() == 0) begin
      set = 1'b1;
    end else if (cc_io.push && cc_io.pop) begin
      nxt = m_stack[m_stack.size() - 1];
      m_stack[m_stack.size() - 1] = pre;
    end else if (cc_io.pop) begin
      nxt = m_stack.pop_back();
    end else if (cc_io.push) begin
      if (m_stack.size() == D) set = 1'b1;
      else m_stack.push_back(pre);
    end
    m_flags = nxt;
    if (set) m_err = 1'b1;
    else if (cc_io.err_clr) m_err = 1'b0;
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_flags = 5'b00010;
      m_stack.delete();
      m_err   = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the clock edges.
  initial forever begin
    @(negedge clk);
    #1;
    check("nzp", 8'({cc_io.N, cc_io.Z, cc_io.P}), 8'(m_flags[2:0]));
    check("br_taken", 8'(cc_io.br_taken), 8'(|(cc_io.br_mask & m_flags[2:0])));
    check("count", 8'(cc_io.stk_count), 8'(m_stack.size()));
    check("full", 8'(cc_io.stk_full), 8'(m_stack.size() == D));
    check("empty", 8'(cc_io.stk_empty), 8'(m_stack.size() == 0));
    check("err", 8'(cc_io.stk_err), 8'(m_err));
`ifdef CC_CV_FLAGS_EN
    check("cv", 8'({cc_io.C, cc_io.V}), 8'(m_flags[4:3]));
`endif
  end

  task automatic idle();
    cc_io.Buss    = '0;
    cc_io.flagWE  = 1'b0;
    cc_io.ld_psr  = 1'b0;
    cc_io.psr_in  = '0;
    cc_io.push    = 1'b0;
    cc_io.pop     = 1'b0;
    cc_io.err_clr = 1'b0;
    cc_io.br_mask = 3'b000;
`ifdef CC_CV_FLAGS_EN
    cc_io.carry_in = 1'b0;
    cc_io.ovf_in   = 1'b0;
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #2;
  endtask

  task automatic lit_nzp(input string name, input logic [2:0] exp);
    check(name, 8'({cc_io.N, cc_io.Z, cc_io.P}), 8'(exp));
  endtask

  initial begin
    idle();
    io8.Buss = '0; io8.flagWE = 1'b0; io8.ld_psr = 1'b0; io8.psr_in = '0;
    io8.push = 1'b0; io8.pop = 1'b0; io8.err_clr = 1'b0; io8.br_mask = 3'b000;
`ifdef CC_CV_FLAGS_EN
    io8.carry_in = 1'b0; io8.ovf_in = 1'b0;
`endif
    #12;
    lit_nzp("lit_reset_nzp", 3'b010);
    check("lit_reset_count", 8'(cc_io.stk_count), 8'd0);
    check("lit_reset_err", 8'(cc_io.stk_err), 8'd0);
    check("lit_reset_empty", 8'(cc_io.stk_empty), 8'd1);
    @(negedge clk); #2;
    reset = 1'b1;

    cc_io.Buss = 16'h8000; cc_io.flagWE = 1'b1;
    io8.Buss = 8'h80; io8.flagWE = 1'b1;
    tick(); idle(); io8.flagWE = 1'b0;
    lit_nzp("lit_neg", 3'b100);
    check("lit_w8_neg", 8'({io8.N, io8.Z, io8.P}), 8'b100);
    cc_io.br_mask = 3'b100; #1;
    check("lit_br_n", 8'(cc_io.br_taken), 8'd1);
    cc_io.br_mask = 3'b011; #1;
    check("lit_br_zp", 8'(cc_io.br_taken), 8'd0);

    cc_io.Buss = 16'h0000; cc_io.flagWE = 1'b1; tick(); idle();
    lit_nzp("lit_zero", 3'b010);
    cc_io.Buss = 16'h0001; cc_io.flagWE = 1'b1; tick(); idle();
    lit_nzp("lit_pos", 3'b001);

    cc_io.push = 1'b1; cc_io.flagWE = 1'b1; cc_io.Buss = 16'hFFFF; tick(); idle();
    lit_nzp("lit_push_we_nzp", 3'b100);
    check("lit_push_we_count", 8'(cc_io.stk_count), 8'd1);
    cc_io.pop = 1'b1; tick(); idle();
    lit_nzp("lit_pop_nzp", 3'b001);
    check("lit_pop_count", 8'(cc_io.stk_count), 8'd0);
    check("lit_pop_err", 8'(cc_io.stk_err), 8'd0);

    for (int i = 1; i <= 5; i++) begin
      cc_io.push = 1'b1; tick(); idle();
      if (i == 4) check("lit_full4", 8'(cc_io.stk_full), 8'd1);
    end
    check("lit_over_err", 8'(cc_io.stk_err), 8'd1);
    check("lit_over_count", 8'(cc_io.stk_count), 8'd4);
    cc_io.err_clr = 1'b1; tick(); idle();
    check("lit_err_clr", 8'(cc_io.stk_err), 8'd0);
    cc_io.ld_psr = 1'b1; cc_io.psr_in = FW'(3'b111); tick(); idle();
    lit_nzp("lit_ld_verbatim", 3'b111);
    for (int i = 1; i <= 5; i++) begin
      cc_io.pop = 1'b1; tick(); idle();
      if (i == 4) lit_nzp("lit_pop4_nzp", 3'b001);
    end
    check("lit_under_err", 8'(cc_io.stk_err), 8'd1);
    lit_nzp("lit_under_nzp", 3'b001);

    cc_io.err_clr = 1'b1; tick(); idle();
    cc_io.ld_psr = 1'b1; cc_io.psr_in = FW'(3'b010); tick(); idle();
    cc_io.push = 1'b1; cc_io.ld_psr = 1'b1; cc_io.psr_in = FW'(3'b100); tick(); idle();
    cc_io.push = 1'b1; cc_io.ld_psr = 1'b1; cc_io.psr_in = FW'(3'b001); tick(); idle();
    check("lit_pre_swap_count", 8'(cc_io.stk_count), 8'd2);
    cc_io.push = 1'b1; cc_io.pop = 1'b1; tick(); idle();
    lit_nzp("lit_swap_nzp", 3'b100);
    check("lit_swap_count", 8'(cc_io.stk_count), 8'd2);
    check("lit_swap_err", 8'(cc_io.stk_err), 8'd0);
    cc_io.pop = 1'b1; tick(); idle();
    lit_nzp("lit_swap_top", 3'b001);
    cc_io.pop = 1'b1; tick(); idle();
    lit_nzp("lit_bottom", 3'b010);
    cc_io.ld_psr = 1'b1; cc_io.psr_in = FW'(3'b100); tick(); idle();
    cc_io.push = 1'b1; cc_io.pop = 1'b1; cc_io.ld_psr = 1'b1; cc_io.psr_in = FW'(3'b010);
    tick(); idle();
    lit_nzp("lit_swap_empty_nzp", 3'b010);
    check("lit_swap_empty_err", 8'(cc_io.stk_err), 8'd1);

    for (int i = 0; i < 3; i++) begin
      cc_io.push = 1'b1; tick(); idle();
    end
    cc_io.ld_psr = 1'b1; cc_io.psr_in = FW'(3'b100); tick(); idle();
    check("lit_pre_rst_count", 8'(cc_io.stk_count), 8'd3);
    #1 reset = 1'b0;
    #1;
    lit_nzp("lit_async_nzp", 3'b010);
    check("lit_async_count", 8'(cc_io.stk_count), 8'd0);
    check("lit_async_err", 8'(cc_io.stk_err), 8'd0);
    @(negedge clk); #2;
    reset = 1'b1;

`ifdef CC_CV_FLAGS_EN
    cc_io.carry_in = 1'b1; cc_io.ovf_in = 1'b1; cc_io.flagWE = 1'b1; cc_io.Buss = 16'h0001;
    tick(); idle();
    cc_io.push = 1'b1; tick(); idle();
    cc_io.flagWE = 1'b1; tick(); idle();
    check("lit_cv_cleared", 8'({cc_io.C, cc_io.V}), 8'b00);
    cc_io.pop = 1'b1; tick(); idle();
    check("lit_cv_restored", 8'({cc_io.C, cc_io.V}), 8'b11);
`endif

    for (int n = 0; n < 2000; n++) begin
      case ($urandom_range(0, 3))
        0: cc_io.Buss = '0;
        1: cc_io.Buss = 16'h8000;
        2: cc_io.Buss = 16'hFFFF;
        default: cc_io.Buss = W'($urandom);
      endcase
      cc_io.flagWE  = ($urandom_range(0, 1) == 1);
      cc_io.ld_psr  = ($urandom_range(0, 4) == 0);
      cc_io.psr_in  = FW'($urandom);
      cc_io.push    = ($urandom_range(0, 9) < 3);
      cc_io.pop     = ($urandom_range(0, 9) < 3);
      cc_io.err_clr = ($urandom_range(0, 9) == 0);
      cc_io.br_mask = 3'($urandom);
`ifdef CC_CV_FLAGS_EN
      cc_io.carry_in = 1'($urandom);
      cc_io.ovf_in   = 1'($urandom);
`endif
      if ($urandom_range(0, 149) == 0) begin
        #1 reset = 1'b0;
        @(negedge clk); #2;
        reset = 1'b1;
      end else begin
        tick();
      end
    end
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cc_flag_unit.md
Name: cc_flag_unit

Overview:
- Parametrised condition-code unit. Successor to the fixed 16-bit N/Z/P flag register.
- Derives N/Z/P from a WIDTH-bit bus value on flagWE.
- Supports direct flag load from the PSR path.
- Keeps a STACK_DEPTH-entry save/restore stack for interrupt entry and return.
- Produces a combinational branch-taken decision for the BR instruction's nzp mask.

Parameters:
- WIDTH, 16, width of Buss; N is taken from bit WIDTH-1.
- STACK_DEPTH, 4, number of flag-stack entries; must be >= 1.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- Buss  input  WIDTH  result value that flags are derived from.
- flagWE  input  1  update flags from Buss.
- ld_psr  input  1  load flags directly from psr_in.
- psr_in  input  3  {N,Z,P} value for ld_psr.
- push  input  1  save current flags onto the stack.
- pop  input  1  restore flags from the top of the stack.
- err_clr  input  1  clear the sticky stk_err.
- br_mask  input  3  {n,z,p} mask from the BR instruction.
- N, Z, P  output  1 each  registered flags.
- br_taken  output  1  |(br_mask & {N,Z,P}), combinational from the registered flags.
- stk_count  output  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- stk_full  output  1  stk_count == STACK_DEPTH.
- stk_empty  output  1  stk_count == 0.
- stk_err  output  1  sticky push-when-full / pop-when-empty indicator.

Behaviour:
- Reset (reset low, asynchronous):
  - {N,Z,P}=3'b010, stk_count=0, stk_err=0.
  - Stack entry contents are not reset.
  - Asserting reset mid-operation aborts any push/pop in that cycle.
- Derived values:
  - Nv = Buss[WIDTH-1].
  - Zv = (Buss == 0).
  - Pv = ~Nv & ~Zv.
  - Exactly one of N/Z/P is ever set after flagWE.
- Flag register next-state priority, highest first:
  - Accepted pop: flags <= top entry.
  - ld_psr: flags <= psr_in, stored verbatim with no one-hot check.
  - flagWE: flags <= {Nv,Zv,Pv}.
  - Otherwise: hold.
- Push:
  - Writes the pre-edge flags (values visible before the clock edge) into entry[stk_count]; count increments.
  - If full: rejected, stk_err <= 1, stack unchanged.
  - Flag-register writes in the same cycle still happen. The stack gets the old flags; the register gets the new ones.
- Pop:
  - If not empty: flags <= entry[stk_count-1]; count decrements.
  - If empty: rejected, stk_err <= 1, count unchanged.
  - After a rejected pop, ld_psr/flagWE still apply at their normal priority.
- Push and pop in the same cycle:
  - Count > 0: swap. Flags <= old top; top <= pre-edge flags; count unchanged; no error.
  - Count = 0: stk_err <= 1; stack, count and flags are unchanged by push/pop; ld_psr/flagWE still apply.
- Latency:
  - Flag, count and err updates are visible one cycle after the sampling edge.
  - br_taken reflects the new flags in that same cycle.
- stk_err:
  - Set has priority over err_clr in the same cycle.
  - Otherwise err_clr clears it.
- Stack storage is a register array indexed by stk_count. There is no wrap-around; count saturates at 0 and STACK_DEPTH by rejection.

Optional Feature:
- Macro CC_CV_FLAGS_EN.
- When defined:
  - Adds inputs carry_in and ovf_in (1 bit each) and outputs C and V.
  - flagWE also captures C<=carry_in and V<=ovf_in.
  - ld_psr widens psr_in to 5 bits {C,V,N,Z,P}.
  - Stack entries are 5 bits and push/pop save/restore C and V too.
  - Reset sets C=V=0.
  - br_taken is unchanged and ignores C/V.
- When undefined:
  - The ports above do not exist.
  - psr_in is 3 bits and stack entries are 3 bits.

Test Plan:
- Reset release, then WIDTH=16, Buss=16'h8000, flagWE -> next cycle {N,Z,P}=100; br_mask=3'b100 -> br_taken=1; br_mask=3'b011 -> br_taken=0.
- Buss=0 with flagWE -> 010; Buss=16'h0001 -> 001; WIDTH=8 build with Buss=8'h80 -> 100.
- Flags=001, push and flagWE with Buss=16'hFFFF in the same cycle -> flags=100, stk_count=1; pop -> flags=001, stk_count=0, stk_err=0.
- STACK_DEPTH=4: push 5 times -> stk_full=1 after the 4th, stk_err=1 after the 5th, count stays 4; err_clr -> stk_err=0; pop 5 times -> 5th pop sets stk_err, flags stay at the value restored by the 4th pop.
- Count=2 with top=100 and flags=001: push+pop together -> flags=100, top=001, count=2. Count=0 with push+pop+ld_psr=3'b010 -> flags=010, stk_err=1.
- Assert reset mid-sequence with count=3 and flags=100, asynchronously between edges -> outputs immediately 010, count 0, err 0. With CC_CV_FLAGS_EN: carry_in=1 and ovf_in=1 with flagWE, push, flagWE with both 0, pop -> C=V=1 restored.
